// File: rtl/divide_two_inputs_seq.sv
// divide_two_inputs_seq
//   Signed fixed-point divider: Q = (A << FRAC_BITS) / B, rounding toward zero.
//   Pops one A/B pair from two first-word-fall-through FIFOs and runs a radix-2
//   restoring divide on the magnitudes, one quotient bit per cycle. It then
//   applies the sign, saturation and divide-by-zero handling, and pushes the
//   result to an output FIFO. At most one operation is in flight.
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   inA_rd_en/_empty/_dout  dividend FIFO (pop, empty flag, signed data)
//   inB_rd_en/_empty/_dout  divisor FIFO
//   out_wr_en/_full/_din    quotient FIFO (push, full flag, registered data)
//   busy                    high whenever not IDLE
//   div_by_zero             pulses with out_wr_en for a B==0 result
module divide_two_inputs_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 0,
  parameter int SATURATE   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  inA_rd_en,
  input  logic                  inA_empty,
  input  logic [DATA_WIDTH-1:0] inA_dout,
  output logic                  inB_rd_en,
  input  logic                  inB_empty,
  input  logic [DATA_WIDTH-1:0] inB_dout,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  busy,
  output logic                  div_by_zero
);
  localparam int W  = DATA_WIDTH;
  localparam int N  = DATA_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_FIX   = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [W-1:0] ONE_W  = W'(1);
  localparam logic [W-1:0] SMAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN   = {1'b1, {(W-1){1'b0}}};
  // Largest magnitudes that still fit the signed result.
  localparam logic [N-1:0] MAGMAX = {{(N-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [N-1:0] MAGMIN = MAGMAX + N'(1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  babs_q, babs_d;
  // The partial remainder never reaches |B|, so W bits hold it; the extra
  // bit exists only in the shifted trial value rem_sh.
  logic [W-1:0]  rem_q, rem_d;
  // Dividend shifts out of the top while quotient bits shift in at the bottom.
  logic [N-1:0]  quo_q, quo_d;
  logic          neg_q, neg_d, zero_q, zero_d, aneg_q, aneg_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          dz_q, dz_d;

  logic          pop;
  logic [W-1:0]  a_abs, b_abs;
  logic [N-1:0]  dvd;
  logic [W:0]    rem_sh;
  logic [W-1:0]  diff;
  logic          ge;
  logic [W-1:0]  neg_low, fix_val;

  // Reset gates the handshakes so nothing is popped or pushed while in reset.
  assign pop         = (state_q == S_IDLE) && !reset && !inA_empty && !inB_empty;
  assign inA_rd_en   = pop;
  assign inB_rd_en   = pop;
  assign out_wr_en   = (state_q == S_WRITE) && !reset && !out_full;
  assign div_by_zero = out_wr_en && dz_q;
  assign busy        = (state_q != S_IDLE);
  assign out_din     = dout_q;

  // Two's complement magnitude; the most negative value maps to 2^(W-1) exactly.
  assign a_abs = inA_dout[W-1] ? (~inA_dout + ONE_W) : inA_dout;
  assign b_abs = inB_dout[W-1] ? (~inB_dout + ONE_W) : inB_dout;

  always_comb begin
    dvd = '0;
    dvd[N-1 -: W] = a_abs;
  end

  assign rem_sh = {rem_q, quo_q[N-1]};
  assign ge     = rem_sh >= {1'b0, babs_q};
  // When ge holds the true difference is below |B|, so the low W bits suffice.
  assign diff   = rem_sh[W-1:0] - babs_q;

  assign neg_low = ~quo_q[W-1:0] + ONE_W;

  always_comb begin
    fix_val = neg_q ? neg_low : quo_q[W-1:0];
    if (zero_q) begin
      fix_val = aneg_q ? SMIN : SMAX;
    end else if (SATURATE != 0) begin
      if (!neg_q && (quo_q > MAGMAX)) fix_val = SMAX;
      if (neg_q && (quo_q > MAGMIN))  fix_val = SMIN;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    babs_d  = babs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    aneg_d  = aneg_q;
    dout_d  = dout_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          babs_d  = b_abs;
          quo_d   = dvd;
          rem_d   = '0;
          neg_d   = inA_dout[W-1] ^ inB_dout[W-1];
          zero_d  = (inB_dout == '0);
          aneg_d  = inA_dout[W-1];
          cnt_d   = CW'(N - 1);
          state_d = (inB_dout == '0) ? S_FIX : S_DIV;
        end
      end
      S_DIV: begin
        rem_d = ge ? diff : rem_sh[W-1:0];
        quo_d = {quo_q[N-2:0], ge};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIX: begin
        dout_d  = fix_val;
        dz_d    = zero_q;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!out_full) begin
          dz_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      babs_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      aneg_q  <= 1'b0;
      dout_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      babs_q  <= babs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      aneg_q  <= aneg_d;
      dout_q  <= dout_d;
      dz_q    <= dz_d;
    end
  end
endmodule
